rf_write_arbiter: RTL and testbench

Shares the single register-file write port (WE3/A3/WD3) between two requesters: requester A (core writeback) and requester B (load/debug writeback). It uses round-robin arbitration, suppresses writes to x0 and registers the selected write toward the register file. An optional post-reset sequencer clears every register to zero before any requester is served. It sits between the writeback sources and the register file, and its outputs drive the register file's write port directly.

---
 rtl/rf_write_arbiter.sv | 118 +++++++++++
 tb/tb_rf_write_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between core (A) and load/debug (B) writeback.
// Define RF_CLEAR_ON_RESET_EN to zero every register through the write port after each reset.
module rf_write_arbiter #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  input  logic [AW-1:0]   a_addr,
  input  logic [XLEN-1:0] a_data,
  output logic            a_ready,
  input  logic            b_valid,
  input  logic [AW-1:0]   b_addr,
  input  logic [XLEN-1:0] b_data,
  output logic            b_ready,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            busy,
  output logic            x0_drop
);

  localparam logic PRIO_A = 1'b0;
  localparam logic PRIO_B = 1'b1;

  if (NREG != (1 << AW)) begin : g_nreg_chk
    $error("NREG must equal 2**AW");
  end

  logic            r_prio;
  logic            r_we;
  logic            r_x0;
  logic [AW-1:0]   r_waddr;
  logic [XLEN-1:0] r_wdata;

  logic            w_run;
  logic            w_clr_we;
  logic [AW-1:0]   w_clr_addr;
  logic            w_a_acc;
  logic            w_b_acc;

`ifdef RF_CLEAR_ON_RESET_EN
  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_RUN   = 1'b1;
  localparam logic [AW:0] CNT_END = (AW+1)'(NREG);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  logic          r_state;
  logic [AW:0]   r_cnt;
  logic          w_clr_done;

  // Counter stops at NREG: that cycle only retires the last clear write and hands over to RUN.
  assign w_clr_done = (r_cnt == CNT_END);
  assign w_run      = (r_state == ST_RUN);
  assign busy       = (r_state == ST_CLEAR);
  assign w_clr_we   = busy && !w_clr_done;
  assign w_clr_addr = r_cnt[AW-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else if (r_state == ST_CLEAR) begin
      if (w_clr_done) r_state <= ST_RUN;
      else            r_cnt   <= r_cnt + CNT_ONE;
    end
  end
`else
  assign w_run      = 1'b1;
  assign busy       = 1'b0;
  assign w_clr_we   = 1'b0;
  assign w_clr_addr = '0;
`endif

  // Ready looks only at the other side's valid, so a requester never waits on itself.
  assign a_ready = w_run && (!b_valid || (r_prio == PRIO_A));
  assign b_ready = w_run && (!a_valid || (r_prio == PRIO_B));
  assign w_a_acc = a_valid && a_ready;
  assign w_b_acc = b_valid && b_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prio  <= PRIO_A;
      r_we    <= 1'b0;
      r_x0    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_clr_we) begin
      r_we    <= 1'b1;
      r_x0    <= 1'b0;
      r_waddr <= w_clr_addr;
      r_wdata <= '0;
    end else if (w_a_acc) begin
      r_prio  <= PRIO_B;
      r_we    <= (a_addr != '0);
      r_x0    <= (a_addr == '0);
      r_waddr <= a_addr;
      r_wdata <= a_data;
    end else if (w_b_acc) begin
      r_prio  <= PRIO_A;
      r_we    <= (b_addr != '0);
      r_x0    <= (b_addr == '0);
      r_waddr <= b_addr;
      r_wdata <= b_data;
    end else begin
      r_we    <= 1'b0;
      r_x0    <= 1'b0;
    end
  end

  assign rf_we    = r_we;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;
  assign x0_drop  = r_x0;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: vector table with a write scoreboard, plus reset/clear sequences.
module tb_rf_write_arbiter;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;
  localparam int NVEC = 15;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            a_valid = 1'b0;
  logic [AW-1:0]   a_addr = '0;
  logic [XLEN-1:0] a_data = '0;
  logic            a_ready;
  logic            b_valid = 1'b0;
  logic [AW-1:0]   b_addr = '0;
  logic [XLEN-1:0] b_data = '0;
  logic            b_ready;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            busy;
  logic            x0_drop;

  rf_write_arbiter #(.XLEN(XLEN), .AW(AW), .NREG(NREG)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy), .x0_drop(x0_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            av;
    logic [AW-1:0]   aa;
    logic [XLEN-1:0] ad;
    logic            bv;
    logic [AW-1:0]   ba;
    logic [XLEN-1:0] bd;
    logic            ear;
    logic            ebr;
  } vec_t;

  typedef struct {
    logic            we;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            x0;
  } wr_t;

  vec_t vec [NVEC];
  wr_t  sb [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input int idx);
    wr_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_underflow at vector %0d: got empty queue expected entry", idx);
      return;
    end
    e = sb.pop_front();
    chk($sformatf("v%0d rf_we", idx), rf_we, e.we);
    chk($sformatf("v%0d x0_drop", idx), x0_drop, e.x0);
    chk($sformatf("v%0d busy", idx), busy, 1'b0);
    if (e.we) begin
      chk($sformatf("v%0d rf_waddr", idx), rf_waddr, e.addr);
      chk($sformatf("v%0d rf_wdata", idx), rf_wdata, e.data);
    end
  endtask

  task automatic clear_run(input int stop_at);
    for (int k = 0; k < NREG; k++) begin
      @(negedge clk);
      chk($sformatf("clr%0d rf_we", k), rf_we, 1'b1);
      chk($sformatf("clr%0d rf_waddr", k), rf_waddr, k);
      chk($sformatf("clr%0d rf_wdata", k), rf_wdata, 32'h0);
      chk($sformatf("clr%0d busy", k), busy, 1'b1);
      chk($sformatf("clr%0d a_ready", k), a_ready, 1'b0);
      if (k == stop_at) return;
    end
  endtask

  initial begin
    wr_t w;
    vec[0]  = '{1'b1, 5'd3, 32'h3,        1'b0, 5'd0, 32'h0,        1'b1, 1'b0};
    vec[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 1'b1};
    vec[2]  = '{1'b1, 5'd5, 32'h0000000A, 1'b0, 5'd0, 32'h0,        1'b1, 1'b1};
    vec[3]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h55,       1'b0, 1'b1};
    vec[4]  = '{1'b1, 5'd6, 32'h11,       1'b1, 5'd7, 32'h22,       1'b1, 1'b0};
    vec[5]  = '{1'b1, 5'd6, 32'h11,       1'b1, 5'd7, 32'h22,       1'b0, 1'b1};
    vec[6]  = '{1'b1, 5'd6, 32'h11,       1'b1, 5'd7, 32'h22,       1'b1, 1'b0};
    vec[7]  = '{1'b1, 5'd6, 32'h11,       1'b1, 5'd7, 32'h22,       1'b0, 1'b1};
    vec[8]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b1};
    vec[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 1'b1};
    vec[10] = '{1'b1, 5'd0, 32'h123,      1'b1, 5'd4, 32'h44,       1'b1, 1'b0};
    vec[11] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 32'h44,       1'b0, 1'b1};
    vec[12] = '{1'b1, 5'd8, 32'hAA,       1'b1, 5'd8, 32'hBB,       1'b1, 1'b0};
    vec[13] = '{1'b1, 5'd8, 32'hAA,       1'b1, 5'd8, 32'hBB,       1'b0, 1'b1};
    vec[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 1'b1};

    a_valid = vec[0].av; a_addr = vec[0].aa; a_data = vec[0].ad;
    repeat (2) @(negedge clk);
    chk("rst rf_we", rf_we, 1'b0);
    chk("rst rf_waddr", rf_waddr, 5'd0);
    chk("rst rf_wdata", rf_wdata, 32'h0);
    chk("rst x0_drop", x0_drop, 1'b0);
`ifdef RF_CLEAR_ON_RESET_EN
    chk("rst busy", busy, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("clr_start busy", busy, 1'b1);
    chk("clr_start a_ready", a_ready, 1'b0);
    chk("clr_start rf_we", rf_we, 1'b0);
    clear_run(10);
    rst = 1'b0;
    #1;
    chk("clr_abort rf_we", rf_we, 1'b0);
    chk("clr_abort rf_waddr", rf_waddr, 5'd0);
    chk("clr_abort busy", busy, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    clear_run(NREG);
    @(negedge clk);
    chk("clr_done busy", busy, 1'b0);
    chk("clr_done rf_we", rf_we, 1'b0);
`else
    chk("rst busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
`endif

    for (int i = 0; i < NVEC; i++) begin
      if (i > 0) begin
        @(negedge clk);
        sb_check(i - 1);
      end
      a_valid = vec[i].av; a_addr = vec[i].aa; a_data = vec[i].ad;
      b_valid = vec[i].bv; b_addr = vec[i].ba; b_data = vec[i].bd;
      #1;
      chk($sformatf("v%0d a_ready", i), a_ready, vec[i].ear);
      chk($sformatf("v%0d b_ready", i), b_ready, vec[i].ebr);
      if (vec[i].av && vec[i].ear)
        w = '{(vec[i].aa != 0), vec[i].aa, vec[i].ad, (vec[i].aa == 0)};
      else if (vec[i].bv && vec[i].ebr)
        w = '{(vec[i].ba != 0), vec[i].ba, vec[i].bd, (vec[i].ba == 0)};
      else
        w = '{1'b0, 5'd0, 32'h0, 1'b0};
      sb.push_back(w);
    end
    @(negedge clk);
    sb_check(NVEC - 1);

    // Reset in the middle of an in-flight write must cancel it and return prio to A.
    a_valid = 1'b1; a_addr = 5'd10; a_data = 32'h77;
    b_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst pre rf_we", rf_we, 1'b1);
    chk("midrst pre rf_waddr", rf_waddr, 5'd10);
    a_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("midrst rf_we", rf_we, 1'b0);
    chk("midrst rf_waddr", rf_waddr, 5'd0);
    chk("midrst rf_wdata", rf_wdata, 32'h0);
    chk("midrst x0_drop", x0_drop, 1'b0);
    @(negedge clk);
    a_valid = 1'b1; a_addr = 5'd11; a_data = 32'hB1;
    b_valid = 1'b1; b_addr = 5'd12; b_data = 32'hB2;
    rst = 1'b1;
`ifdef RF_CLEAR_ON_RESET_EN
    #1;
    chk("midrst busy", busy, 1'b1);
    clear_run(NREG);
    @(negedge clk);
`endif
    #1;
    chk("midrst busy_after", busy, 1'b0);
    chk("midrst a_ready", a_ready, 1'b1);
    chk("midrst b_ready", b_ready, 1'b0);
    @(negedge clk);
    chk("midrst post rf_we", rf_we, 1'b1);
    chk("midrst post rf_waddr", rf_waddr, 5'd11);
    chk("midrst post rf_wdata", rf_wdata, 32'hB1);
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
